// File: rtl/sram_controller.sv
// sram_controller: MEM-stage data access onto a 16-bit async SRAM.
// Each 32-bit word is moved as two halfword phases of WAIT_CYCLES each.
module sram_controller #(
  parameter logic [31:0] BASE_ADDR = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic               ready,
  output logic [31:0]        read_data,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t             state;
  logic [3:0]         cnt;
  logic [SRAM_AW-2:0] wordAddr;
  logic [31:0]        wrData;
  logic               opWrite;

  logic [31:0]        offset;
  logic [SRAM_AW-2:0] reqWord;
  logic               unusedOffset;
  logic               req;
  logic               lastCyc;

  assign req     = mem_r_en | mem_w_en;
  assign offset  = (address - BASE_ADDR) >> 2;
  assign reqWord = offset[SRAM_AW-2:0];
  // Upper word bits fall off the SRAM: out-of-range addresses wrap.
  assign unusedOffset = ^offset[31:SRAM_AW-1];
  assign lastCyc = (cnt == LAST);
  assign ready   = (state == DONE) | ((state == IDLE) & ~req);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      wordAddr    <= '0;
      wrData      <= '0;
      opWrite     <= 1'b0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            state       <= LOW;
            cnt         <= '0;
            wordAddr    <= reqWord;
            wrData      <= write_data;
            opWrite     <= mem_w_en;
            sram_addr   <= {reqWord, 1'b0};
            sram_dq_out <= mem_w_en ? write_data[15:0] : 16'h0;
            sram_dq_oe  <= mem_w_en;
            sram_we_n   <= ~mem_w_en;
            sram_oe_n   <= mem_w_en;
          end
        end
        LOW: begin
          if (lastCyc) begin
            if (!opWrite) read_data[15:0] <= sram_dq_in;
            state       <= HIGH;
            cnt         <= '0;
            sram_addr   <= {wordAddr, 1'b1};
            sram_dq_out <= opWrite ? wrData[31:16] : 16'h0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HIGH: begin
          if (lastCyc) begin
            if (!opWrite) read_data[31:16] <= sram_dq_in;
            state       <= DONE;
            cnt         <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed vectors for sram_controller.
// DUT A runs WAIT_CYCLES=2, DUT B runs WAIT_CYCLES=1.
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic        rdA, wrA, rdB, wrB;
  logic [31:0] addrA, addrB, wdA, wdB;
  logic        readyA, readyB;
  logic [31:0] rdDataA, rdDataB;
  logic [17:0] saA, saB;
  logic [15:0] dqoA, dqoB, dqiA, dqiB;
  logic        dqOeA, dqOeB, weA, weB, oeA, oeB;

  logic [15:0] memA [64];
  logic [15:0] memB [64];

  int nChk;
  int nFail;
  bit useB;

  logic        rdyS, weS, oeS, dqOeS;
  logic [31:0] rdS;
  logic [17:0] saS;
  logic [15:0] dqoS;

  typedef struct {
    bit          useB;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] a0;
    logic [31:0] expRead;
  } vec_t;

  vec_t tbl [10];

  sram_controller #(.WAIT_CYCLES(2)) dutA (
    .clk(clk), .rst(rst),
    .mem_r_en(rdA), .mem_w_en(wrA),
    .address(addrA), .write_data(wdA),
    .ready(readyA), .read_data(rdDataA),
    .sram_addr(saA), .sram_dq_out(dqoA),
    .sram_dq_oe(dqOeA), .sram_dq_in(dqiA),
    .sram_we_n(weA), .sram_oe_n(oeA)
  );

  sram_controller #(.WAIT_CYCLES(1)) dutB (
    .clk(clk), .rst(rst),
    .mem_r_en(rdB), .mem_w_en(wrB),
    .address(addrB), .write_data(wdB),
    .ready(readyB), .read_data(rdDataB),
    .sram_addr(saB), .sram_dq_out(dqoB),
    .sram_dq_oe(dqOeB), .sram_dq_in(dqiB),
    .sram_we_n(weB), .sram_oe_n(oeB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural async SRAMs, 64 halfwords each.
  always @(posedge clk) begin
    if (!weA) memA[saA[5:0]] <= dqoA;
    if (!weB) memB[saB[5:0]] <= dqoB;
  end
  assign dqiA = oeA ? 16'h0 : memA[saA[5:0]];
  assign dqiB = oeB ? 16'h0 : memB[saB[5:0]];

  always_comb begin
    rdyS  = useB ? readyB  : readyA;
    rdS   = useB ? rdDataB : rdDataA;
    saS   = useB ? saB     : saA;
    dqoS  = useB ? dqoB    : dqoA;
    dqOeS = useB ? dqOeB   : dqOeA;
    weS   = useB ? weB     : weA;
    oeS   = useB ? oeB     : oeA;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic dropReq();
    rdA = 1'b0; wrA = 1'b0;
    rdB = 1'b0; wrB = 1'b0;
  endtask

  task automatic doAccess(input int idx, input vec_t v);
    int w;
    bit hi;
    string t;
    w = v.useB ? 1 : 2;
    @(posedge clk);
    #1;
    useB = v.useB;
    if (v.useB) begin
      rdB = v.rd; wrB = v.wr; addrB = v.addr; wdB = v.wdata;
    end else begin
      rdA = v.rd; wrA = v.wr; addrA = v.addr; wdA = v.wdata;
    end
    @(negedge clk);
    t = $sformatf("v%0d", idx);
    chk({t, " c0 ready"}, 32'(rdyS), 32'd0);
    for (int c = 1; c <= 2 * w; c++) begin
      @(negedge clk);
      hi = (c > w);
      chk($sformatf("%s c%0d addr", t, c), 32'(saS), 32'(v.a0 + 18'(hi)));
      chk($sformatf("%s c%0d ready", t, c), 32'(rdyS), 32'd0);
      chk($sformatf("%s c%0d we_n", t, c), 32'(weS), 32'(!v.wr));
      chk($sformatf("%s c%0d oe_n", t, c), 32'(oeS), 32'(v.wr));
      chk($sformatf("%s c%0d dq_oe", t, c), 32'(dqOeS), 32'(v.wr));
      if (v.wr)
        chk($sformatf("%s c%0d dq_out", t, c), 32'(dqoS),
            32'(hi ? v.wdata[31:16] : v.wdata[15:0]));
    end
    @(negedge clk);
    chk({t, " done ready"}, 32'(rdyS), 32'd1);
    chk({t, " done read_data"}, rdS, v.expRead);
    chk({t, " done we_n"}, 32'(weS), 32'd1);
    chk({t, " done oe_n"}, 32'(oeS), 32'd1);
    chk({t, " done addr"}, 32'(saS), 32'd0);
    @(posedge clk);
    #1;
    dropReq();
    @(negedge clk);
    chk({t, " idle ready"}, 32'(rdyS), 32'd1);
    chk({t, " idle read_data"}, rdS, v.expRead);
  endtask

  initial begin
    nChk  = 0;
    nFail = 0;
    useB  = 1'b0;
    rst   = 1'b0;
    dropReq();
    addrA = '0; addrB = '0; wdA = '0; wdB = '0;
    for (int i = 0; i < 64; i++) begin
      memA[i] = '0;
      memB[i] = '0;
    end

    tbl[0] = '{1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 18'd2, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'd1028, 32'h0, 18'd2, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 32'd1032, 32'h11112222, 18'd4, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 32'd1024, 32'h0000CAFE, 18'd0, 32'hDEADBEEF};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 32'd1024, 32'h0, 18'd0, 32'h0000CAFE};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'd1032, 32'h0, 18'd4, 32'h11112222};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 32'd1020, 32'hA5A55A5A, 18'h3FFFE, 32'h11112222};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 32'd1020, 32'h0, 18'h3FFFE, 32'hA5A55A5A};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 32'd1024, 32'h12345678, 18'd0, 32'h0};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 18'd0, 32'h12345678};

    #12;
    chk("reset ready", 32'(readyA), 32'd1);
    chk("reset read_data", rdDataA, 32'd0);
    chk("reset we_n", 32'(weA), 32'd1);
    chk("reset oe_n", 32'(oeA), 32'd1);
    chk("reset dq_oe", 32'(dqOeA), 32'd0);
    chk("reset addr", 32'(saA), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 10; i++) doAccess(i, tbl[i]);

    // Reset in the middle of a store, then restart with request held.
    useB = 1'b0;
    @(posedge clk);
    #1;
    wrA = 1'b1; addrA = 32'd1028; wdA = 32'hDEADBEEF;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre-rst we_n", 32'(weA), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst we_n", 32'(weA), 32'd1);
    chk("rst dq_oe", 32'(dqOeA), 32'd0);
    chk("rst oe_n", 32'(oeA), 32'd1);
    chk("rst addr", 32'(saA), 32'd0);
    chk("rst read_data", rdDataA, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("restart c0 ready", 32'(readyA), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("restart c%0d addr", c), 32'(saA), 32'(c > 2 ? 3 : 2));
      chk($sformatf("restart c%0d we_n", c), 32'(weA), 32'd0);
      chk($sformatf("restart c%0d ready", c), 32'(readyA), 32'd0);
    end
    @(negedge clk);
    chk("restart c5 ready", 32'(readyA), 32'd1);
    @(posedge clk);
    #1;
    dropReq();
    @(negedge clk);
    chk("restart mem lo", 32'(memA[2]), 32'h0000BEEF);
    chk("restart mem hi", 32'(memA[3]), 32'h0000DEAD);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChk, nFail);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sequences the MEM-stage data memory access onto an external 16-bit asynchronous SRAM.
- Takes the load/store request from the EXE-stage pipeline register (ALU result as address, Rm value as store data).
- Splits each 32-bit word into two 16-bit halfword accesses with programmable wait states.
- Drives `ready` low while busy; top level derives the pipeline freeze as (mem_r_en | mem_w_en) & ~ready.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 2: cycles per halfword access phase. Legal range 1..15.
- SRAM_AW, 18: SRAM halfword address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- mem_r_en  in  1  load request; held stable until ready=1.
- mem_w_en  in  1  store request; held stable until ready=1.
- address  in  32  byte address (ALU result).
- write_data  in  32  store data.
- ready  out  1  access complete / controller idle.
- read_data  out  32  last completed load word.
- sram_addr  out  SRAM_AW  halfword address.
- sram_dq_out  out  16  write data to SRAM.
- sram_dq_oe  out  1  1 = controller drives DQ.
- sram_dq_in  in  16  read data from SRAM.
- sram_we_n  out  1  write enable, active-low.
- sram_oe_n  out  1  output enable, active-low.

Behaviour:
- Address map:
  - word_addr = (address - BASE_ADDR) >> 2, modulo arithmetic in 32 bits.
  - Halfword address = {word_addr, half}, truncated to SRAM_AW bits. Out-of-range addresses wrap silently.
- State machine (registered) IDLE -> LOW -> HIGH -> DONE -> IDLE. Wait counter is 4 bits.
- IDLE:
  - If mem_w_en or mem_r_en: latch address, write_data and op (write if mem_w_en=1, including when both are high), clear counter, go to LOW.
  - Otherwise stay.
- LOW: half=0, dq = write_data[15:0]. After WAIT_CYCLES cycles go to HIGH and clear counter. On a read, capture sram_dq_in into read_data[15:0] in the last LOW cycle.
- HIGH: half=1, dq = write_data[31:16]. On a read, capture read_data[31:16] in the last HIGH cycle. After WAIT_CYCLES cycles go to DONE.
- DONE: unconditional return to IDLE. A new request is accepted only in IDLE.
- ready = (state==DONE) | (state==IDLE & ~mem_r_en & ~mem_w_en). Combinational from state and request.
- Latency:
  - Request seen in IDLE at cycle 0; ready=1 in cycle 2*WAIT_CYCLES+1 (cycle 5 at default).
  - Back-to-back requests incur one IDLE cycle between them.
- SRAM outputs by state:
  - Write, LOW/HIGH: sram_we_n=0, sram_dq_oe=1, sram_oe_n=1.
  - Read, LOW/HIGH: sram_oe_n=0, sram_we_n=1, sram_dq_oe=0.
  - IDLE/DONE: we_n=1, oe_n=1, dq_oe=0, sram_addr=0, sram_dq_out=0.
- read_data:
  - Changes only during read phases.
  - Holds its value across writes and idle periods.
  - Is valid in DONE and afterwards.
- Reset (rst=0, any time including mid-access):
  - State=IDLE, counter=0, latched address/data/op=0, read_data=0.
  - we_n=1, oe_n=1, dq_oe=0 immediately (asynchronous).
  - An interrupted write leaves SRAM content undefined. After release, a held request restarts from LOW.

Test Plan:
- Reset with no request -> ready=1, read_data=0, sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, sram_addr=0.
- Store 0xDEADBEEF @1028, WAIT_CYCLES=2:
  - Cycles 1-2: sram_addr=2, dq_out=0xBEEF, we_n=0, dq_oe=1.
  - Cycles 3-4: sram_addr=3, dq_out=0xDEAD.
  - Cycle 5: ready=1.
  - Cycle 6: IDLE.
- Load @1028 against a behavioural SRAM model holding the above -> oe_n=0 in cycles 1-4, ready=1 in cycle 5, read_data=0xDEADBEEF; read_data unchanged after a subsequent store to 1032.
- WAIT_CYCLES=1, store then load @1024 of 0x12345678 -> each access has ready=1 in cycle 3; loaded value 0x12345678; sram_addr sequence 0,1.
- Assert rst in cycle 2 of a store -> we_n=1 and dq_oe=0 in the same cycle; after release with request held, sram_addr=2 access restarts and ready=1 five cycles later.
- mem_r_en=mem_w_en=1 with write_data 0x0000CAFE @1024 -> write performed (we_n=0), read_data keeps its prior value, ready=1 in cycle 5.
